// File: rtl/brush_line_writer_if.sv
// Command and pixel-write bundle for the brush line writer.
// The master issues cursor commands; the slave drives the pixel store.
interface brush_line_writer_if #(
  parameter int COORD_W = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [COORD_W-1:0] cmd_x;
  logic [COORD_W-1:0] cmd_y;
  logic [2:0]         cmd_color;
  logic               cmd_pen;
  logic               cmd_clear;
  logic [COORD_W-1:0] wx;
  logic [COORD_W-1:0] wy;
  logic [2:0]         newColor;
  logic               we;
  logic               busy;

  modport master (
    output cmd_valid, cmd_x, cmd_y,
    output cmd_color, cmd_pen, cmd_clear,
    input  cmd_ready, wx, wy,
    input  newColor, we, busy
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y,
    input  cmd_color, cmd_pen, cmd_clear,
    output cmd_ready, wx, wy,
    output newColor, we, busy
  );
endinterface

// File: rtl/brush_line_writer.sv
// Canvas write-stream producer: pen moves, Bresenham lines
// and full-canvas clears, one pixel write per cycle.
module brush_line_writer #(
  parameter int COORD_W    = 8,
  parameter int CANVAS_MAX = 127
) (
  input logic clk,
  input logic reset,
  brush_line_writer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LINE  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [COORD_W-1:0] CMAX =
    COORD_W'(CANVAS_MAX);

  state_t state, state_nx;

  logic [COORD_W-1:0] tx, ty;
  logic [COORD_W-1:0] lx, ly;
  logic [COORD_W-1:0] cx, cy;
  logic [COORD_W-1:0] x1, y1;
  logic [COORD_W-1:0] adx, ady;
  logic [2:0]         color;
  logic               sx_neg, sy_neg;
  logic               accept;
  logic               at_end;
  logic               clr_end;
  logic               step_x, step_y;

  logic signed [9:0]  err;
  logic signed [9:0]  dxs, dys;
  logic signed [9:0]  dx_n, dy_n;
  logic signed [9:0]  err_nx;
  logic signed [10:0] e2, dx11, dy11;

  assign tx = (bus.cmd_x > CMAX) ? CMAX : bus.cmd_x;
  assign ty = (bus.cmd_y > CMAX) ? CMAX : bus.cmd_y;

  assign accept  = bus.cmd_valid && (state == IDLE);
  assign at_end  = (cx == x1) && (cy == y1);
  assign clr_end = (cx == CMAX) && (cy == CMAX);

  // Line setup is taken from the last pen position.
  assign adx  = (lx < tx) ? tx - lx : lx - tx;
  assign ady  = (ly < ty) ? ty - ly : ly - ty;
  assign dx_n = signed'(10'(adx));
  assign dy_n = -signed'(10'(ady));

  assign e2   = {err, 1'b0};
  assign dx11 = dxs;
  assign dy11 = dys;

  assign step_x = (e2 >= dy11);
  assign step_y = (e2 <= dx11);

  always_comb begin
    err_nx = err;
    if (step_x) err_nx = err_nx + dys;
    if (step_y) err_nx = err_nx + dxs;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_clear)    state_nx = CLEAR;
          else if (bus.cmd_pen) state_nx = LINE;
        end
      end
      LINE:    if (at_end)  state_nx = IDLE;
      CLEAR:   if (clr_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lx     <= '0;
      ly     <= '0;
      cx     <= '0;
      cy     <= '0;
      x1     <= '0;
      y1     <= '0;
      color  <= '0;
      err    <= '0;
      dxs    <= '0;
      dys    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (bus.cmd_clear) begin
              cx    <= '0;
              cy    <= '0;
              color <= bus.cmd_color;
            end else if (bus.cmd_pen) begin
              cx     <= lx;
              cy     <= ly;
              x1     <= tx;
              y1     <= ty;
              color  <= bus.cmd_color;
              dxs    <= dx_n;
              dys    <= dy_n;
              err    <= dx_n + dy_n;
              sx_neg <= !(lx < tx);
              sy_neg <= !(ly < ty);
            end else begin
              lx <= tx;
              ly <= ty;
            end
          end
        end
        LINE: begin
          if (at_end) begin
            lx <= x1;
            ly <= y1;
          end else begin
            err <= err_nx;
            if (step_x) cx <= sx_neg ? cx - 1'b1 : cx + 1'b1;
            if (step_y) cy <= sy_neg ? cy - 1'b1 : cy + 1'b1;
          end
        end
        CLEAR: begin
          if (clr_end) begin
            lx <= '0;
            ly <= '0;
          end else if (cx == CMAX) begin
            cx <= '0;
            cy <= cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Write coordinates track the walker, so they hold while idle.
  always_comb begin
    bus.we        = (state != IDLE);
    bus.busy      = (state != IDLE);
    bus.cmd_ready = (state == IDLE);
    bus.wx        = cx;
    bus.wy        = cy;
    bus.newColor  = color;
  end

endmodule
